// File: rtl/tiniest_gpu_pkg.sv
// tiniest_gpu_pkg: shared types and constants for the GPU front end.
package tiniest_gpu_pkg;
    typedef enum logic [1:0] {IA_IDLE, IA_PAYLOAD, IA_CHECK, IA_DONE} ia_state_t;
    localparam logic [7:0] IA_SYNC_BYTE      = 8'hA5;
    localparam int         IA_PAYLOAD_LEN    = 55;
    localparam int         IA_TIMEOUT_CYCLES = 20000;
    localparam logic [5:0] IA_IDX_PAD        = 6'd50;
    localparam logic [5:0] IA_IDX_LAST       = 6'd54;
    // register-file decode: three triangle vertices, light, matrix, pad, control
    localparam logic [5:0] IA_IDX_TRI0_BASE  = 6'd0;
    localparam logic [5:0] IA_IDX_TRI1_BASE  = 6'd9;
    localparam logic [5:0] IA_IDX_TRI2_BASE  = 6'd18;
    localparam logic [5:0] IA_IDX_LIGHT_BASE = 6'd27;
    localparam logic [5:0] IA_IDX_MAT_BASE   = 6'd33;
    localparam logic [5:0] IA_IDX_CTRL_BASE  = 6'd51;
endpackage

// File: rtl/ia_timeout.sv
// ia_timeout: saturating inter-byte timer; clear reloads zero, expired holds at CYCLES-1.
module ia_timeout #(
    parameter int CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = $clog2(CYCLES);
    localparam logic [W-1:0] LIMIT = W'(CYCLES - 1);
    logic [W-1:0] timer_q, timer_d;
    assign expired_o = timer_q == LIMIT;
    always_comb timer_d = clear_i ? '0 : (enable_i && !expired_o) ? timer_q + W'(1) : timer_q;
    always_ff @(posedge clk) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end
endmodule

// File: rtl/input_assembler.sv
// input_assembler: locks onto a sync byte and turns UART bytes into register-write strobes.
// Define IA_CHECKSUM_EN to require a trailing 8-bit payload sum byte per frame.
module input_assembler
    import tiniest_gpu_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = IA_SYNC_BYTE,
    parameter int         PAYLOAD_LEN    = IA_PAYLOAD_LEN,
    parameter int         TIMEOUT_CYCLES = IA_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] byte_out,
    output logic [5:0] idx,
    output logic       update_reg,
    output logic       pc_ready,
    output logic       busy,
    output logic       err
);
    localparam logic [5:0] LAST = 6'(PAYLOAD_LEN - 1);
`ifdef IA_CHECKSUM_EN
    localparam ia_state_t AFTER_LAST = IA_CHECK;
`else
    localparam ia_state_t AFTER_LAST = IA_DONE;
`endif
    ia_state_t  state_q, state_d;
    logic [5:0] count_q, count_d, idx_q, idx_d;
    logic [7:0] byte_q, byte_d;
    logic       upd_q, upd_d, pc_q, pc_d, err_q, err_d;
    logic       in_frame, expired, timeout, start, wr, wr_last, sum_ok, bad;
    assign in_frame = state_q == IA_PAYLOAD || state_q == IA_CHECK;
    assign timeout  = in_frame && !rx_done && expired;
    // DONE accepts a sync exactly like IDLE so back-to-back frames lose no byte
    assign start    = rx_done && rx_data == SYNC_BYTE && (state_q == IA_IDLE || state_q == IA_DONE);
    assign wr       = rx_done && state_q == IA_PAYLOAD;
    assign wr_last  = wr && count_q == LAST;
    ia_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (rx_done || !in_frame),
        .enable_i (in_frame),
        .expired_o(expired)
    );
`ifdef IA_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       bad_q;
    assign sum_ok = rx_data == sum_q;
    assign bad    = bad_q;
    always_comb sum_d = start ? 8'd0 : wr ? sum_q + rx_data : sum_q;
    // mismatch is flagged one cycle late so err lines up with where pc_ready would land
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            bad_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            bad_q <= rx_done && state_q == IA_CHECK && !sum_ok;
        end
    end
`else
    assign sum_ok = 1'b1;
    assign bad    = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IA_IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = IA_IDLE;
        case (state_q)
            IA_IDLE, IA_DONE: state_d = start ? IA_PAYLOAD : IA_IDLE;
            IA_PAYLOAD:       state_d = timeout ? IA_IDLE : wr_last ? AFTER_LAST : IA_PAYLOAD;
            IA_CHECK:         state_d = timeout || (rx_done && !sum_ok) ? IA_IDLE : rx_done ? IA_DONE : IA_CHECK;
            default:          state_d = IA_IDLE;
        endcase
    end
    always_comb busy = state_q != IA_IDLE;
    always_comb begin
        count_d = start ? 6'd0 : wr ? count_q + 6'd1 : count_q;
        upd_d   = wr;
        byte_d  = wr ? rx_data : byte_q;
        idx_d   = wr ? count_q : idx_q;
        pc_d    = state_q == IA_DONE;
        err_d   = timeout || bad;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            upd_q   <= 1'b0;
            pc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            upd_q   <= upd_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end
    assign byte_out   = byte_q;
    assign idx        = idx_q;
    assign update_reg = upd_q;
    assign pc_ready   = pc_q;
    assign err        = err_q;
endmodule

// File: tb/tb_input_assembler.sv
// tb_input_assembler: randomized frames checked every cycle against a frame-level model.
module tb_input_assembler;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int PL = 55;
    localparam int TO = 50;
`ifdef IA_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0, rst_n, rx_done;
    logic [7:0] rx_data, byte_out;
    logic [5:0] idx;
    logic update_reg, pc_ready, busy, err;

    input_assembler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .byte_out(byte_out), .idx(idx), .update_reg(update_reg),
        .pc_ready(pc_ready), .busy(busy), .err(err)
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int n_upd = 0, n_pc = 0, n_err = 0, pc_cyc = 0, last_rx = 0;
    int seen_idx = 0, seen_byte = 0;
    logic [7:0] pl [PL];

    // model: frame-level rules, outputs scheduled into a small ring indexed by cycle
    int mode = 0, nb = 0, last_rx_m = 0, mn, mm, k;
    bit fin;
    logic [7:0] msum = 0, cur_byte = 0;
    logic [5:0] cur_idx = 0;
    logic e_upd [4], e_pc [4], e_err [4], e_busy [4];
    logic [7:0] e_byte [4];
    logic [5:0] e_idx [4];

    initial forever begin
        @(posedge clk);
        mn = (cyc + 1) % 4;
        mm = (cyc + 2) % 4;
        e_pc[mm] = 1'b0;
        e_err[mm] = 1'b0;
        e_upd[mn] = 1'b0;
        fin = 1'b0;
        if (!rst_n) begin
            mode = 0;
            cur_byte = 0;
            cur_idx = 0;
            e_pc[mn] = 1'b0;
            e_err[mn] = 1'b0;
        end else if (rx_done) begin
            if (mode == 0) begin
                if (rx_data == SYNC) begin
                    mode = 1;
                    nb = 0;
                    msum = 0;
                end
            end else if (mode == 1) begin
                e_upd[mn] = 1'b1;
                cur_byte = rx_data;
                cur_idx = 6'(nb);
                msum += rx_data;
                nb++;
                if (nb == PL) begin
                    mode = CK ? 2 : 0;
                    if (!CK) begin
                        e_pc[mm] = 1'b1;
                        fin = 1'b1;
                    end
                end
            end else begin
                mode = 0;
                if (rx_data == msum) begin
                    e_pc[mm] = 1'b1;
                    fin = 1'b1;
                end else e_err[mm] = 1'b1;
            end
            last_rx_m = cyc;
        end else if (mode != 0 && cyc - last_rx_m == TO) begin
            mode = 0;
            e_err[mn] = 1'b1;
        end
        e_busy[mn] = mode != 0 || fin;
        e_byte[mn] = cur_byte;
        e_idx[mn] = cur_idx;
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            k = cyc % 4;
            checks++;
            if (update_reg !== e_upd[k] || pc_ready !== e_pc[k] || busy !== e_busy[k] ||
                err !== e_err[k] || byte_out !== e_byte[k] || idx !== e_idx[k]) begin
                failures++;
                $display("FAIL cycle %0d upd/pc/busy/err/idx/byte got %b/%b/%b/%b/%0d/%h want %b/%b/%b/%b/%0d/%h",
                         cyc, update_reg, pc_ready, busy, err, idx, byte_out,
                         e_upd[k], e_pc[k], e_busy[k], e_err[k], e_idx[k], e_byte[k]);
            end
            if (update_reg === 1'b1) begin
                n_upd++;
                seen_idx = int'(idx);
                seen_byte = int'(byte_out);
            end
            if (pc_ready === 1'b1) begin
                n_pc++;
                pc_cyc = cyc;
            end
            if (err === 1'b1) n_err++;
        end
    end

    task automatic expect_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        last_rx = cyc;
        tick();
        rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic int g(input int gap);
        return gap < 0 ? int'($urandom_range(1, 4)) : gap;
    endfunction

    task automatic frame(input int n, input int gap, input int last_gap, input logic [7:0] ck_xor,
                         input int long_at, input int long_gap);
        logic [7:0] s = 0;
        bool_last: begin end
        send(SYNC, g(gap));
        for (int i = 0; i < n; i++) begin
            s += pl[i];
            send(pl[i], (i == n - 1 && !(CK && n == PL)) ? last_gap : (i == long_at) ? long_gap : g(gap));
        end
        if (CK && n == PL) send(s ^ ck_xor, last_gap);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < PL; i++) pl[i] = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
    endtask

    int pc0, e0, u0, kind;

    initial begin
        rst_n = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        expect_eq("reset_busy", busy, 0);
        expect_eq("reset_update_reg", update_reg, 0);
        rst_n = 1'b1;

        send(8'h11, 2);
        send(8'h22, 2);
        expect_eq("junk_busy", busy, 0);
        expect_eq("junk_strobes", n_upd, 0);

        for (int i = 0; i < PL; i++) pl[i] = 8'(i);
        frame(PL, 2, 4, 8'h00, -1, 0);
        expect_eq("ramp_strobes", n_upd, 55);
        expect_eq("ramp_last_idx", seen_idx, 54);
        expect_eq("ramp_last_byte", seen_byte, 8'h36);
        expect_eq("ramp_pc_latency", pc_cyc - last_rx, 2);
        expect_eq("ramp_pc_count", n_pc, 1);
        expect_eq("ramp_err_count", n_err, 0);

        pc0 = n_pc; e0 = n_err;
        rand_payload();
        frame(10, 2, 2, 8'h00, -1, 0);
        repeat (TO + 4) tick();
        expect_eq("timeout_err", n_err - e0, 1);
        expect_eq("timeout_pc", n_pc - pc0, 0);
        expect_eq("timeout_busy", busy, 0);
        u0 = n_upd; pc0 = n_pc;
        frame(PL, -1, 4, 8'h00, -1, 0);
        expect_eq("after_timeout_strobes", n_upd - u0, 55);
        expect_eq("after_timeout_pc", n_pc - pc0, 1);

`ifdef IA_CHECKSUM_EN
        u0 = n_upd; pc0 = n_pc; e0 = n_err;
        send(SYNC, 2);
        for (int i = 0; i < PL; i++) send(8'h01, 2);
        send(8'h37, 4);
        expect_eq("ck_good_pc", n_pc - pc0, 1);
        expect_eq("ck_good_strobes", n_upd - u0, 55);
        u0 = n_upd; pc0 = n_pc;
        send(SYNC, 2);
        for (int i = 0; i < PL; i++) send(8'h01, 2);
        send(8'h36, 4);
        expect_eq("ck_bad_pc", n_pc - pc0, 0);
        expect_eq("ck_bad_err", n_err - e0, 1);
        expect_eq("ck_bad_strobes", n_upd - u0, 55);
`endif

        rand_payload();
        frame(31, 2, 2, 8'h00, -1, 0);
        reset_pulse();
        expect_eq("midreset_busy", busy, 0);
        expect_eq("midreset_idx", idx, 0);
        expect_eq("midreset_byte", byte_out, 0);
        pc0 = n_pc;
        frame(PL, -1, 4, 8'h00, -1, 0);
        expect_eq("after_reset_pc", n_pc - pc0, 1);

        pc0 = n_pc; e0 = n_err;
        rand_payload();
        frame(PL, 2, 4, 8'h00, 5, TO - 1);
        expect_eq("coincide_err", n_err - e0, 0);
        expect_eq("coincide_pc", n_pc - pc0, 1);

        pc0 = n_pc;
        frame(PL, 2, 0, 8'h00, -1, 0);
        frame(PL, 2, 4, 8'h00, -1, 0);
        expect_eq("done_sync_pc", n_pc - pc0, 2);

        for (int it = 0; it < 40; it++) begin
            rand_payload();
            repeat ($urandom_range(0, 3)) send(8'($urandom_range(0, 8'hA4)), g(-1));
            kind = $urandom_range(0, 9);
            if (kind <= 5)      frame(PL, -1, g(-1), 8'h00, -1, 0);
            else if (kind == 6) frame($urandom_range(1, PL - 1), -1, TO + 2, 8'h00, -1, 0);
            else if (kind == 7) frame(PL, -1, 3, 8'($urandom_range(1, 255)), -1, 0);
            else if (kind == 8) begin
                frame($urandom_range(1, PL - 1), -1, 1, 8'h00, -1, 0);
                reset_pulse();
            end else frame(PL, -1, 3, 8'h00, $urandom_range(0, PL - 2), TO - 1 + $urandom_range(0, 1));
        end
        repeat (TO + 4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/input_assembler.md
# input_assembler

Frame assembler between the UART receiver and the GPU's triangle/light/matrix register file. It consumes received bytes, locks onto a sync byte, and emits one register-write strobe per payload byte with its byte index 0–54. It raises a one-cycle `pc_ready` when a complete frame has arrived; the top level registers this into `pc_data_ready` to start the vertex stage. An inter-byte timeout aborts stalled frames, and an optional checksum rejects corrupted frames.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `PAYLOAD_LEN`, 55: payload bytes per frame; indices 0..PAYLOAD_LEN-1.
- `TIMEOUT_CYCLES`, 20000: idle clocks tolerated between bytes inside a frame.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `rx_data` in 8: received byte; held stable by the UART until its next `rx_done`.
- `rx_done` in 1: one-cycle pulse, `rx_data` valid.
- `byte_out` out 8: registered copy of the payload byte being written.
- `idx` out 6: register index of `byte_out`.
- `update_reg` out 1: one-cycle write strobe; `byte_out`/`idx` valid.
- `pc_ready` out 1: one-cycle pulse, frame complete (and checksum good when enabled).
- `busy` out 1: high while a frame is in progress (not IDLE).
- `err` out 1: one-cycle pulse on timeout abort or checksum mismatch.

## Operation
- States: IDLE, PAYLOAD, CHECK (only with checksum), DONE.
- IDLE:
  - `rx_done` with `rx_data==SYNC_BYTE` → PAYLOAD; count←0; sum←0; timer←0.
  - Any other byte is ignored.
- PAYLOAD, on each `rx_done`:
  - `update_reg`=1, `idx`=count, `byte_out`=rx_data; sum←sum+rx_data (mod 256); count←count+1; timer←0.
  - After index PAYLOAD_LEN-1: → CHECK when checksum is enabled, else → DONE.
  - Bytes equal to SYNC_BYTE inside the payload are data. There is no resync.
- Index 50 is a pad slot. It is strobed like any other index; the register file ignores it.
- CHECK, on `rx_done`:
  - rx_data==sum → DONE.
  - Otherwise `err` pulse → IDLE.
  - The checksum byte never produces `update_reg`.
- DONE: lasts one cycle; `pc_ready`=1; → IDLE. An `rx_done` arriving in DONE is handled by IDLE rules in the same cycle (a SYNC starts a new frame).
- Timeout:
  - In PAYLOAD/CHECK the timer increments every cycle without `rx_done`.
  - When timer reaches TIMEOUT_CYCLES-1: `err` pulse → IDLE.
  - If `rx_done` and timer expiry coincide, the byte wins and the timer clears.
- Registers already written by an aborted frame stay written. Consumers act only on `pc_ready`.
- Widths: count is 6 bits; timer is $clog2(TIMEOUT_CYCLES) bits and saturates at expiry; sum is 8-bit wrapping.

## Timing
- Reset values:
  - `byte_out`=0, `idx`=0, `update_reg`=0, `pc_ready`=0, `busy`=0, `err`=0.
  - State IDLE; count, sum and timer all 0.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs at reset values. No `pc_ready` or `err` is emitted.
- Payload byte: `rx_done` at cycle n → `update_reg`/`idx`/`byte_out` at n+1.
- Frame completion, no checksum: last payload `rx_done` at n → its `update_reg` at n+1, `pc_ready` at n+2. The register write therefore lands before `pc_ready` is sampled.
- Frame completion, with checksum: checksum `rx_done` at n → `pc_ready` or `err` at n+2.
- `busy` rises the cycle after the sync `rx_done` and falls the cycle after DONE or abort.
- Throughput: one byte per `rx_done`. The UART's byte period far exceeds 2 cycles, so no backpressure exists.

## Configuration
- `IA_CHECKSUM_EN` defined:
  - Frame is SYNC + PAYLOAD_LEN bytes + 1 checksum byte (8-bit sum of payload).
  - Mismatch gives `err` and no `pc_ready`.
- Undefined:
  - CHECK state and sum logic are absent.
  - Frame is SYNC + PAYLOAD_LEN bytes; `pc_ready` follows the last payload byte.

## Structure
- Shared package `tiniest_gpu_pkg` holds:
  - the state enum `ia_state_t`;
  - `IA_SYNC_BYTE`, `IA_PAYLOAD_LEN`, `IA_IDX_PAD`=50, `IA_IDX_LAST`=54;
  - the index constants used by the top-level register decode.
- One sub-module `ia_timeout`: a loadable, saturating inter-byte timer with `clear`, `enable` and `expired` signals.

## Test plan
- Sync 0xA5, then bytes 0x00..0x36: 55 `update_reg` pulses with `idx`=`byte_out`=0..54, each one cycle after its `rx_done`; `pc_ready` 2 cycles after the last `rx_done`; `err`=0.
- Bytes 0x11, 0x22 before sync: no strobes, `busy`=0. Then a full frame: normal completion.
- Sync + 10 bytes, then silence for TIMEOUT_CYCLES: `err` pulse, `busy`→0, no `pc_ready`. A following full frame completes with `idx` restarting at 0.
- With `IA_CHECKSUM_EN`, payload all 0x01:
  - checksum 0x37 → `pc_ready`;
  - checksum 0x36 → `err`, no `pc_ready`;
  - no `update_reg` for the checksum byte in either case.
- `rst_n` low for 1 cycle after byte 30: all outputs 0, state IDLE. A fresh frame then completes normally.
- `rx_done` in the same cycle the timer reaches TIMEOUT_CYCLES-1: byte accepted, no `err`.
